alu_seq: RTL and testbench

- Parametrised, handshaked successor of the single-cycle datapath ALU.
- Supports the same logic and arithmetic opcodes, plus multi-cycle unsigned multiply, divide and remainder.
- Latches its operands, registers its result and flags, and holds them until the consumer accepts.
- Sits between the decode/register-read stage and writeback in the multi-cycle CNN datapath.

---
 rtl/alu_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU that latches a request, registers result/flags and holds them until accepted.
// Define ALU_SEQ_MULDIV_EN to build the iterative MUL/DIVU/REMU datapath (BUSY state).
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd12;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;
`endif

    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
        $error("alu_seq: CNT_W too narrow to count WIDTH iterations");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] add_r;
    logic [WIDTH-1:0] sub_r;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic             sc_dz;
    logic             go_multi;
    logic             accept;
    logic             load_out;
    logic [WIDTH-1:0] fin_res;
    logic             fin_ovf;
    logic             fin_dz;

    assign add_r  = a + b;
    assign sub_r  = a - b;
    assign accept = (state == S_IDLE) && in_valid;

    // Single-cycle result, plus detection of ops that need the iterative datapath
    always_comb begin
        sc_res   = '0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        go_multi = 1'b0;
        case (aluctl)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_ADD: begin
                sc_res = add_r;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_r;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: sc_res = WIDTH'(a < b);
            OP_XOR:  sc_res = a ^ b;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL:  go_multi = 1'b1;
            OP_DIVU: begin
                if (b == '0) begin
                    sc_res = '1;
                    sc_dz  = 1'b1;
                end else begin
                    go_multi = 1'b1;
                end
            end
            OP_REMU: begin
                if (b == '0) begin
                    sc_res = a;
                    sc_dz  = 1'b1;
                end else begin
                    go_multi = 1'b1;
                end
            end
`endif
            default: sc_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic [3:0]       md_op;
    logic [WIDTH-1:0] md_opd;
    logic [WIDTH-1:0] md_acc;
    logic [WIDTH-1:0] md_mq;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mq_n;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic             last_iter;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // One iteration: shift-add multiply or restoring divide (quotient bits enter md_mq LSB)
    always_comb begin
        mul_sum = {1'b0, md_acc} + (md_mq[0] ? {1'b0, md_opd} : {(WIDTH + 1){1'b0}});
        div_sh  = {md_acc, md_mq[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, md_opd});
        div_sub = div_sh[WIDTH-1:0] - md_opd;
        acc_n   = md_acc;
        mq_n    = md_mq;
        if (md_op == OP_MUL) begin
            acc_n = mul_sum[WIDTH:1];
            mq_n  = {mul_sum[0], md_mq[WIDTH-1:1]};
        end else begin
            acc_n = div_ge ? div_sub : div_sh[WIDTH-1:0];
            mq_n  = {md_mq[WIDTH-2:0], div_ge};
        end
    end

    // Operand latch and iteration state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_op  <= '0;
            md_opd <= '0;
            md_acc <= '0;
            md_mq  <= '0;
            cnt    <= '0;
        end else if (accept && go_multi) begin
            md_op  <= aluctl;
            md_opd <= (aluctl == OP_MUL) ? a : b;
            md_mq  <= (aluctl == OP_MUL) ? b : a;
            md_acc <= '0;
            cnt    <= '0;
        end else if (state == S_BUSY) begin
            md_acc <= acc_n;
            md_mq  <= mq_n;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_n = go_multi ? S_BUSY : S_DONE;
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_BUSY: begin
                if (last_iter) begin
                    state_n = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == S_IDLE);
            out_valid <= (state_n == S_DONE);
        end
    end

    // Select which result is captured, and when
    always_comb begin
        load_out = accept && !go_multi;
        fin_res  = sc_res;
        fin_ovf  = sc_ovf;
        fin_dz   = sc_dz;
`ifdef ALU_SEQ_MULDIV_EN
        if ((state == S_BUSY) && last_iter) begin
            load_out = 1'b1;
            fin_dz   = 1'b0;
            fin_ovf  = (md_op == OP_MUL) && (acc_n != '0);
            if (md_op == OP_MUL || md_op == OP_DIVU) begin
                fin_res = mq_n;
            end else begin
                fin_res = acc_n;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out      <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else if (load_out) begin
            out      <= fin_res;
            zero     <= (fin_res == '0);
            overflow <= fin_ovf;
            div_zero <= fin_dz;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): issue pushes expectations, the monitor checks results.
// MUL/DIVU/REMU expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    typedef struct {
        logic [31:0] out;
        logic        zero;
        logic        ovf;
        logic        dz;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        zero;
    logic        overflow;
    logic        div_zero;

    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   cyc        = 0;
    int   wr_ptr     = 0;
    int   rd_ptr     = 0;
    int   timeouts   = 0;
    bit   final_req  = 1'b0;
    bit   final_done = 1'b0;
    bit   have_cur   = 1'b0;
    bit   prev_valid = 1'b0;
    bit   prev_rst   = 1'b1;
    exp_t exp_mem[64];
    exp_t cur;

    alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluctl    (aluctl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] o, input logic z, input logic v,
                                input logic d, input int lat);
        exp_t e;
        e.out     = o;
        e.zero    = z;
        e.ovf     = v;
        e.dz      = d;
        e.lat     = lat;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Without the mul/div datapath, opcodes 8/9/10 behave as unknown opcodes
    function automatic exp_t mdx(input logic [31:0] o, input logic z, input logic v,
                                 input logic d, input int lat);
        if (MD) return mk(o, z, v, d, lat);
        return mk(32'd0, 1'b1, 1'b0, 1'b0, 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with in_valid still high
    task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input exp_t e);
        int   n;
        exp_t ee;
        in_valid = 1'b1;
        aluctl   = op;
        a        = aa;
        b        = bb;
        n        = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeouts++;
            in_valid = 1'b0;
        end else begin
            ee         = e;
            ee.acc_cyc = cyc + 1;
            exp_mem[wr_ptr % 64] = ee;
            wr_ptr++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Monitor: pops an expectation when out_valid rises and checks it every cycle it stays high
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out", out, 32'd0);
            chk("rst_zero", 32'(zero), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            chk("rst_div_zero", 32'(div_zero), 32'd0);
            rd_ptr     = wr_ptr;
            have_cur   = 1'b0;
            prev_valid = 1'b0;
            prev_rst   = 1'b1;
        end else begin
            if (prev_rst) chk("release_in_ready", 32'(in_ready), 32'd1);
            prev_rst = 1'b0;
            if (out_valid) begin
                if (!prev_valid) begin
                    if (rd_ptr == wr_ptr) begin
                        chk("unexpected_result", 32'(out_valid), 32'd0);
                    end else begin
                        cur = exp_mem[rd_ptr % 64];
                        rd_ptr++;
                        have_cur = 1'b1;
                        chk("latency", 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
                    end
                end
                if (have_cur) begin
                    chk("out", out, cur.out);
                    chk("zero", 32'(zero), 32'(cur.zero));
                    chk("overflow", 32'(overflow), 32'(cur.ovf));
                    chk("div_zero", 32'(div_zero), 32'(cur.dz));
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                end
            end else begin
                have_cur = 1'b0;
            end
            prev_valid = out_valid;
            if (final_req && !final_done) begin
                chk("issue_timeouts", 32'(timeouts), 32'd0);
                chk("results_drained", 32'(rd_ptr), 32'(wr_ptr));
                final_done = 1'b1;
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        aluctl    = '0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Signed overflow, result held while the consumer stalls
        out_ready = 1'b0;
        issue(4'd2, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1));
        idle();
        repeat (5) @(negedge clk);
        out_ready = 1'b1;

        issue(4'd6,  32'd5,        32'd5,        mk(32'h0,         1'b1, 1'b0, 1'b0, 1));
        issue(4'd7,  32'd3,        32'hFFFF_FFFF, mk(32'h1,        1'b0, 1'b0, 1'b0, 1));
        issue(4'd12, 32'hF0F0_F0F0, 32'hFFFF_FFFF, mk(32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 1));
        issue(4'd0,  32'hFF00_FF00, 32'h0FF0_0FF0, mk(32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1));
        issue(4'd1,  32'hFF00_FF00, 32'h0FF0_0FF0, mk(32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1));
        issue(4'd6,  32'h8000_0000, 32'h1,        mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1));
        issue(4'd2,  32'hFFFF_FFFF, 32'h1,        mk(32'h0,         1'b1, 1'b0, 1'b0, 1));
        issue(4'd7,  32'hFFFF_FFFF, 32'd3,        mk(32'h0,         1'b1, 1'b0, 1'b0, 1));
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0,        1'b1, 1'b0, 1'b0, 1));
        issue(4'd3,  32'h1,        32'h1,        mk(32'h0,         1'b1, 1'b0, 1'b0, 1));
        idle();

        // Multiply, divide, remainder, including divide by zero
        issue(4'd8,  32'h0001_0000, 32'h0001_0000, mdx(32'h0,        1'b1, 1'b1, 1'b0, 33));
        issue(4'd8,  32'd1234,     32'd5678,     mdx(32'd7006652,  1'b0, 1'b0, 1'b0, 33));
        issue(4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, mdx(32'h1,       1'b0, 1'b1, 1'b0, 33));
        issue(4'd9,  32'd100,      32'd7,        mdx(32'd14,       1'b0, 1'b0, 1'b0, 33));
        issue(4'd10, 32'd100,      32'd7,        mdx(32'd2,        1'b0, 1'b0, 1'b0, 33));
        issue(4'd9,  32'd9,        32'd0,        mdx(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1));
        issue(4'd10, 32'd9,        32'd0,        mdx(32'd9,        1'b0, 1'b0, 1'b1, 1));
        issue(4'd9,  32'hFFFF_FFFF, 32'd1,        mdx(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33));
        issue(4'd10, 32'hFFFF_FFFE, 32'hFFFF_FFFF, mdx(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33));
        issue(4'd9,  32'd6,        32'd7,        mdx(32'd0,        1'b1, 1'b0, 1'b0, 33));
        idle();

        // Asynchronous reset 10 cycles into a divide: the operation is abandoned
        issue(4'd9, 32'd1000, 32'd3, mdx(32'd333, 1'b0, 1'b0, 1'b0, 33));
        idle();
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        issue(4'd2, 32'd2, 32'd3, mk(32'd5, 1'b0, 1'b0, 1'b0, 1));
        idle();
        repeat (2) @(negedge clk);

        // Back-to-back: in_valid stays high, next request presented while DONE
        issue(4'd6,  32'd10, 32'd3, mk(32'd7, 1'b0, 1'b0, 1'b0, 1));
        issue(4'd8,  32'd3,  32'd4, mdx(32'd12, 1'b0, 1'b0, 1'b0, 33));
        issue(4'd2,  32'd1,  32'd1, mk(32'd2, 1'b0, 1'b0, 1'b0, 1));
        issue(4'd15, 32'd7,  32'd9, mk(32'd0, 1'b1, 1'b0, 1'b0, 1));
        issue(4'd10, 32'd50, 32'd8, mdx(32'd2, 1'b0, 1'b0, 1'b0, 33));
        issue(4'd12, 32'hA5A5_A5A5, 32'h5A5A_5A5A, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1));
        idle();

        n = 0;
        while ((rd_ptr != wr_ptr || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        final_req = 1'b1;
        n = 0;
        while (!final_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
